// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg
// Shared widths and types for the register file with pending-write scoreboard.
// No ports; imported by the interface, the counter and the top module.
package reg_file_sb_pkg;

    localparam int DataSize    = 32;
    localparam int RegAddrSize = 5;
    localparam int RegNum      = 32;

    typedef logic [DataSize-1:0]    data_t;
    typedef logic [RegAddrSize-1:0] addr_t;

endpackage : reg_file_sb_pkg

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if
// Bundles the decoder-side issue/read signals and the write-back port.
//   master : decoder / write-back driver (drives addresses, issue and write-back)
//   slave  : reg_file_sb (returns operands, stall, issueAccept, sbError)
//
// Handshake: an instruction is presented with issueValid=1 and is taken in
// the cycle where issueAccept (= issueValid && !stall) is 1. There is no
// registered ready; while stall=1 the decoder must hold all issue inputs
// stable. The write-back port has no back-pressure: wbEnable=1 always lands.
interface reg_file_sb_if;
    import reg_file_sb_pkg::*;

    addr_t rs1Addr;
    addr_t rs2Addr;
    logic  rs1Used;
    logic  rs2Used;
    logic  issueValid;
    logic  writeEnableReg;
    addr_t writeBackAddrIn;
    logic  wbEnable;
    addr_t wbAddr;
    data_t wbData;
    data_t dataReg1;
    data_t dataReg2;
    logic  stall;
    logic  issueAccept;
    logic  sbError;

    modport master (
        output rs1Addr, rs2Addr, rs1Used, rs2Used, issueValid,
               writeEnableReg, writeBackAddrIn, wbEnable, wbAddr, wbData,
        input  dataReg1, dataReg2, stall, issueAccept, sbError
    );

    modport slave (
        input  rs1Addr, rs2Addr, rs1Used, rs2Used, issueValid,
               writeEnableReg, writeBackAddrIn, wbEnable, wbAddr, wbData,
        output dataReg1, dataReg2, stall, issueAccept, sbError
    );

endinterface : reg_file_sb_if

// File: rtl/reg_file_sb_sb_counter.sv
// sb_counter
// Per-register in-flight write counter: saturating up/down, never wraps.
//   clk, rst     : clock, async active-high reset
//   inc_i        : an accepted issue targets this register
//   dec_i        : a write-back targets this register
//   cnt_o        : current pending count
//   underflow_o  : write-back seen while count is zero (combinational)
//   full_o       : count is at its maximum
module sb_counter #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [PEND_W-1:0] cnt_o,
    output logic              underflow_o,
    output logic              full_o
);

    logic [PEND_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        // Simultaneous inc and dec cancel out, including at zero.
        if (inc_i && !dec_i) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o       = cnt_q;
    assign underflow_o = dec_i && (cnt_q == '0);
    assign full_o      = (cnt_q == '1);

endmodule : sb_counter

// File: rtl/reg_file_sb.sv
// reg_file_sb
// Architectural register file (x1..x31, x0 hard-wired to 0) with a
// pending-write scoreboard that stalls issue on unresolved source operands
// or on a saturated destination counter.
//   clk, rst : clock, async active-high reset
//   bus      : reg_file_sb_if.slave -- issue/read inputs, write-back port,
//              operands, stall, issueAccept, sticky sbError
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave bus
);

    data_t             regs_q [RegNum];
    logic [PEND_W-1:0] pend   [RegNum];
    logic [RegNum-1:0] inc, dec, underflow, full;
    logic              hazard1, hazard2, full_hazard, stall, issue_accept;
    logic              err_q;

    // x0 is never tracked.
    assign pend[0]      = '0;
    assign inc[0]       = 1'b0;
    assign dec[0]       = 1'b0;
    assign underflow[0] = 1'b0;
    assign full[0]      = 1'b0;

    for (genvar r = 1; r < RegNum; r++) begin : g_sb
        assign inc[r] = issue_accept && bus.writeEnableReg &&
                        (bus.writeBackAddrIn == RegAddrSize'(r));
        assign dec[r] = bus.wbEnable && (bus.wbAddr == RegAddrSize'(r));

        sb_counter #(.PEND_W(PEND_W)) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .inc_i      (inc[r]),
            .dec_i      (dec[r]),
            .cnt_o      (pend[r]),
            .underflow_o(underflow[r]),
            .full_o     (full[r])
        );
    end

    // A source whose only outstanding write is landing this cycle is served
    // by the bypass, so it does not stall.
    always_comb begin
        hazard1 = bus.rs1Used && (bus.rs1Addr != '0) && (pend[bus.rs1Addr] != '0) &&
                  !(bus.wbEnable && (bus.wbAddr == bus.rs1Addr) &&
                    (pend[bus.rs1Addr] == PEND_W'(1)));
        hazard2 = bus.rs2Used && (bus.rs2Addr != '0) && (pend[bus.rs2Addr] != '0) &&
                  !(bus.wbEnable && (bus.wbAddr == bus.rs2Addr) &&
                    (pend[bus.rs2Addr] == PEND_W'(1)));
        // A same-cycle write-back frees one slot, so a full counter can accept.
        full_hazard = bus.writeEnableReg && (bus.writeBackAddrIn != '0) &&
                      full[bus.writeBackAddrIn] &&
                      !(bus.wbEnable && (bus.wbAddr == bus.writeBackAddrIn));
        stall        = bus.issueValid && (hazard1 || hazard2 || full_hazard);
        issue_accept = bus.issueValid && !stall;
    end

    always_comb begin
        bus.dataReg1 = '0;
        bus.dataReg2 = '0;
        if (bus.rs1Addr != '0) begin
            if (bus.wbEnable && (bus.wbAddr == bus.rs1Addr)) bus.dataReg1 = bus.wbData;
            else                                             bus.dataReg1 = regs_q[bus.rs1Addr];
        end
        if (bus.rs2Addr != '0) begin
            if (bus.wbEnable && (bus.wbAddr == bus.rs2Addr)) bus.dataReg2 = bus.wbData;
            else                                             bus.dataReg2 = regs_q[bus.rs2Addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RegNum; i++) regs_q[i] <= '0;
        end else if (bus.wbEnable && (bus.wbAddr != '0)) begin
            regs_q[bus.wbAddr] <= bus.wbData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             err_q <= 1'b0;
        else if (|underflow) err_q <= 1'b1;
    end

    assign bus.stall       = stall;
    assign bus.issueAccept = issue_accept;
    assign bus.sbError     = err_q;

endmodule : reg_file_sb

// File: doc/reg_file_sb.md
# reg_file_sb

Architectural register file with a pending-write scoreboard, on the write-back end of the decode→ALU pipeline register. Supplies `dataReg1`/`dataReg2` to the decode/ALU pipeline register. Tracks every destination register issued by the decoder until its write-back arrives, and raises `stall` when a source operand is not yet valid. Closes the loop that `writeEnable`/`writeBackAddr` open when they leave decode.

## Interface
Parameters:
- `PEND_W`, 2: width of the per-register in-flight counter; max in-flight writes per register = 2^PEND_W − 1.

Ports (widths via `DataSize` = 32 bits, `RegAddrSize` = 5 bits):
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  reset; asynchronous, active-high.
- `rs1Addr`, `rs2Addr`  in  5  source register addresses from decoder.
- `rs1Used`, `rs2Used`  in  1  the source is actually read by the decoded instruction.
- `issueValid`  in  1  decoder presents an instruction this cycle.
- `writeEnableReg`  in  1  issued instruction writes a register.
- `writeBackAddrIn`  in  5  destination register of issued instruction.
- `wbEnable`  in  1  write-back port valid.
- `wbAddr`  in  5  write-back destination.
- `wbData`  in  32  write-back data.
- `dataReg1`, `dataReg2`  out  32  source operand values, combinational.
- `stall`  out  1  the issued instruction must be held; combinational.
- `issueAccept`  out  1  `issueValid && !stall`.
- `sbError`  out  1  sticky; write-back to a register with zero pending count.

## Operation
- Storage: 31 × 32-bit registers (x1..x31). x0 reads 0 and is never written or tracked.
- Read: `dataRegN` = 0 if `rsNAddr`==0. Otherwise = `wbData` if `wbEnable && wbAddr==rsNAddr` (write bypass). Otherwise the stored value.
- Write: on posedge, if `wbEnable && wbAddr!=0`, `regs[wbAddr] <= wbData`.
- Scoreboard: per-register counter `pend[r]` (PEND_W bits).
  - Increment when `issueAccept && writeEnableReg && writeBackAddrIn==r`.
  - Decrement when `wbEnable && wbAddr==r`.
  - Both in the same cycle on the same r: counter unchanged.
- Source hazard for N: `rsNUsed && rsNAddr!=0 && pend[rsNAddr]!=0`. The hazard is cleared by bypass when `wbEnable && wbAddr==rsNAddr && pend[rsNAddr]==1`.
- Full hazard: `writeEnableReg && writeBackAddrIn!=0 && pend[writeBackAddrIn]` is all-ones, and no decrement on that register this cycle.
- `stall = issueValid && (hazard1 || hazard2 || fullHazard)`. Stalled issues do not touch the scoreboard.
- Underflow: write-back with `pend[wbAddr]==0` and `wbAddr!=0`:
  - the data write still happens;
  - the counter stays 0 and does not wrap;
  - `sbError <= 1` (sticky until reset).
- Write-back to x0 is ignored entirely and flags no error.

## Timing
- Reset (async assert):
  - all registers = 0;
  - all `pend` = 0;
  - `sbError` = 0.
  - `dataReg1`/`dataReg2` read 0; `stall` is 0 unless a bypass-free hazard would exist, which is impossible with empty counters.
- Reset deasserted mid-operation: all in-flight tracking is discarded. Later write-backs of pre-reset instructions flag `sbError`.
- Read latency 0: a same-cycle write-back is visible through the bypass. The stored value is updated at the next posedge.
- Scoreboard latency 1: an accepted issue in cycle t makes the register pending from cycle t+1. The write-back in cycle t is reflected from t+1.
- `stall` and `issueAccept` are purely combinational from inputs and current state. There is no registered handshake, so the decoder holds its inputs while `stall`=1.

## Structure
- `DataSize`, `RegAddrSize` and the register count constant come from the shared `define.v`. Add `RegNum` (32) there if it is absent.
- One natural sub-module, `sb_counter`, per-register saturating up/down counter with underflow flag; instantiated 31 times via generate.
- Register array and bypass muxes stay in the top module.

## Test plan
- Reset, then read rs1=5, rs2=0 with `rs1Used`=`rs2Used`=1 → `dataReg1`=0, `dataReg2`=0, `stall`=0.
- Issue write to x7 (accepted); next cycle read rs1=7 → `stall`=1. Write-back x7=0x1234_5678 in that cycle with pend=1 → `stall`=0, `dataReg1`=0x1234_5678 via bypass.
- Issue x3 three times with no write-back → third accepted; fourth issue to x3 → `stall`=1 (full). Write-back x3 in the same cycle → fourth accepted, pend stays 3.
- Issue to x9 and write-back x9 in the same cycle from pend=1 → pend remains 1. Read of x9 next cycle → `stall`=1.
- Write-back x4=0xDEAD_BEEF with pend[x4]=0 → x4 updated, `sbError`=1 and stays 1. Async `rst` pulse mid-cycle → `sbError`=0 immediately, x4 reads 0.
- Write-back x0=0xFFFF_FFFF → x0 still reads 0, `sbError` unchanged. Issue with dest x0 → no scoreboard change, never stalls.
